// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings and defaults.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEF_CLK_HZ = 12000000;
  localparam int DEF_BAUD   = 115200;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: restartable bit-period divider.
// tick_o is high on the last cycle of each bit period.
module uart_baud_tick #(
  parameter int CLKS = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (CLKS > 1) ? $clog2(CLKS) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  // count 0..CLKS-1 while enabled; clear restarts a bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || !en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter.
// One-entry holding register gives gap-free frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int BAUD      = DEF_BAUD,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CLKS_IN_BAUD = CLK_HZ / BAUD;
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == PAR_ODD);
  localparam logic HAS_PAR = (PARITY != PAR_NONE);

  if (CLKS_IN_BAUD < 2) begin : g_bad_clks
    $error("uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        ready_q;
  logic [2:0]  bit_q;
  logic        tx_q;
  logic        done_q;

  logic tick;
  logic accept;
  logic last_stop;
  logic launch_new;
  logic restart_d;

  assign accept     = tx_valid && ready_q;
  assign last_stop  = (state_q == S_STOP) && tick
                   && (bit_q == LAST_STOP);
  assign launch_new = accept
                   && ((state_q == S_IDLE) || last_stop);
  assign restart_d  = launch_new || (last_stop && hold_full_q);

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign busy     = (state_q != S_IDLE) || hold_full_q;

  uart_baud_tick #(
    .CLKS (CLKS_IN_BAUD)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != S_IDLE),
    .clr_i  (restart_d),
    .tick_o (tick)
  );

  // frame sequencer, holding register and registered line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      bit_q       <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= last_stop;
      if (accept && !launch_new) begin
        hold_q      <= tx_byte;
        hold_full_q <= 1'b1;
        ready_q     <= 1'b0;
      end
      if (restart_d) begin
        state_q <= S_START;
        bit_q   <= '0;
        tx_q    <= 1'b0;
        if (launch_new) begin
          shift_q <= tx_byte;
        end else begin
          shift_q     <= hold_q;
          hold_full_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      end else if (last_stop) begin
        state_q <= S_IDLE;
        tx_q    <= 1'b1;
      end else if (tick) begin
        unique case (state_q)
          S_START: begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
          S_DATA: begin
            if (bit_q == 3'd7) begin
              bit_q <= '0;
              if (HAS_PAR) begin
                state_q <= S_PARITY;
                tx_q    <= (^shift_q) ^ ODD;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[bit_q + 3'd1];
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
          S_STOP: begin
            bit_q <= bit_q + 3'd1;
          end
          default: begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Byte-serial UART transmitter; the transmit-direction counterpart of the team's UART receiver, with matching baud arithmetic and frame format. Accepts bytes over a valid/ready handshake into a one-entry holding register. Serialises each byte as start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. Frames go out back-to-back with no idle gap when the holding register is already loaded.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s; CLKS_IN_BAUD = CLK_HZ / BAUD (integer division, 104 at defaults)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_byte  input  8  byte to send, sampled on handshake
tx_valid  input  1  tx_byte is valid
tx_ready  output  1  holding register empty; a byte can be accepted
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress or holding register full
tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
- One clock; reset is asynchronous and active-low: clk and rst_n.
- Reset values: tx=1, tx_ready=1, busy=0, tx_done=0. Reset clears the holding register, shift register, baud counter and bit index; state = S_IDLE.
- Reset mid-frame: tx returns to 1 immediately (asynchronous). The truncated frame is abandoned and not resumed.
- Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready. tx_ready = !hold_full, registered. tx_byte is don't-care when tx_valid = 0.
- Launch from S_IDLE with hold empty: the accepted byte bypasses the holding register. It goes straight to the shift register, and tx=0 is driven from that same edge. The start bit occupies the next CLKS_IN_BAUD cycles. tx_ready stays 1.
- Holding register: a byte accepted while a frame is active loads hold and sets hold_full; tx_ready drops on the next cycle.
- FSM states: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP. Every bit lasts exactly CLKS_IN_BAUD cycles. The baud counter runs 0..CLKS_IN_BAUD-1, and the bit advances when the counter equals CLKS_IN_BAUD-1.
- S_START -> S_DATA.
- S_DATA sends bits 0..7 using bit index 0..7. After bit 7 it goes to S_PARITY if PARITY != 0, else to S_STOP.
- Parity bit: even = XOR of the 8 data bits; odd = its inverse.
- S_STOP holds tx=1 for STOP_BITS*CLKS_IN_BAUD cycles.
- End of the last stop-bit cycle:
  - tx_done pulses for exactly one cycle.
  - If hold_full: hold moves to the shift register, hold_full clears, tx=0 on the same edge, and the next frame starts with zero idle cycles.
  - Otherwise: go to S_IDLE.
- A tx_valid handshake coinciding with the final stop-bit edge while hold is empty is accepted and launched on that edge, also gap-free.
- busy = (state != S_IDLE) || hold_full.
- Frame length = (1 + 8 + (PARITY != 0) + STOP_BITS) * CLKS_IN_BAUD cycles.
- Baud counter width = $clog2(CLKS_IN_BAUD).
- Elaboration error if CLKS_IN_BAUD < 2, PARITY > 2, or STOP_BITS is not 1 or 2.
- tx is driven only from a flop; no combinational path from tx_byte or the FSM state to tx.

Decomposition:
- Package uart_pkg holds:
  - state encodings S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  - parity constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2
  - default CLK_HZ and BAUD, so the receiver and transmitter share one source
- One sub-module, uart_baud_tick: a restartable divider that emits a tick on the last cycle of each bit period. The clear input is driven at every frame launch.

Test Plan:
- Defaults, PARITY=0, STOP_BITS=1, send 0x55 from idle -> tx low for 104 cycles, then bits 1,0,1,0,1,0,1,0 at 104 cycles each, then stop high. tx_done pulses at cycle 1040 after the accept edge; busy=0 on the next cycle.
- PARITY=2, send 0xA5 -> parity bit 0, 11-bit frame of 1144 cycles. PARITY=1, same byte -> parity bit 1.
- STOP_BITS=2, send 0x00 -> tx high for 208 cycles after bit 7; tx_done at cycle 1144.
- Hold tx_valid with 0x00 then 0xFF -> both accepted, tx_ready low while 0xFF waits. The second start bit begins exactly 1040 cycles after the first, with no idle high cycle between frames. Exactly two tx_done pulses.
- Assert rst_n=0 for 3 cycles mid-data-bit of 0x0F -> tx=1 asynchronously, tx_ready=1, busy=0, no tx_done. A subsequent send of 0x3C produces a clean full frame.
- tx_valid asserted on the final stop-bit edge with hold empty -> byte launched on that edge; start bit follows with zero gap.
